uart_tx_fifo: RTL

Transmit-side buffer sitting directly upstream of the UART transmitter. The host/game logic pushes bytes at clock rate; the transmitter pulls them one per frame. The FIFO presents its head word first-word-fall-through on `tx_din` and drives `tx_start` whenever it is non-empty. It pops on the rising edge of the transmitter's `tx_fifo_rd` strobe, so a strobe stretched over several clocks still consumes exactly one byte.

---
 rtl/uart_pkg.sv | 7 +
 rtl/fifo_ctrl.sv | 63 ++++++
 rtl/uart_tx_fifo.sv | 83 ++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART parameter defaults.
//   UART_DATA_W  : byte width used by the transmitter and its buffer
//   FIFO_ADDR_W  : transmit FIFO address width (depth = 2**FIFO_ADDR_W)
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int FIFO_ADDR_W = 4;
endpackage

// File: rtl/fifo_ctrl.sv
// Pointer and occupancy control for the UART transmit FIFO.
// Qualifies raw push/pop requests against full/empty and tracks the pointers,
// the explicit occupancy count and the registered full/empty flags.
//   clk, reset_n : clock, async active-low reset
//   wr           : raw push request
//   pop_req      : raw pop request (already edge-detected)
//   push, pop    : qualified operations
//   w_ptr, r_ptr : array write/read addresses
//   count        : occupancy 0..depth
//   full, empty  : registered flags, consistent with count
module fifo_ctrl
  import uart_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr,
  input  logic              pop_req,
  output logic              push,
  output logic              pop,
  output logic [ADDR_W-1:0] w_ptr,
  output logic [ADDR_W-1:0] r_ptr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty
);

  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(2**ADDR_W);

  logic [ADDR_W:0] count_nxt;

  // A pop in the same cycle frees the slot, so a push is legal even when full.
  assign pop  = pop_req & ~empty;
  assign push = wr & (~full | pop);

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push) w_ptr <= w_ptr + 1'b1;
      if (pop)  r_ptr <= r_ptr + 1'b1;
      count <= count_nxt;
      // Flags come from next-count so they never lag the count register.
      full  <= (count_nxt == DEPTH);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit-side FIFO feeding the UART transmitter, first-word-fall-through.
// The head word is presented on tx_din and tx_start requests a frame whenever
// the FIFO holds data; the transmitter's tx_fifo_rd strobe pops on its rising
// edge only, so a stretched strobe consumes exactly one byte.
//   clk, reset_n : clock, async active-low reset
//   wr, w_data   : host push request and byte
//   tx_fifo_rd   : transmitter pop strobe (rising edge pops)
//   clr_ovf      : synchronous clear of overflow
//   tx_din       : head word, 0 when empty
//   tx_start     : !empty
//   full, empty  : registered occupancy flags
//   count        : occupancy 0..depth
//   overflow     : sticky, set when a write is dropped
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr,
  input  logic [DATA_W-1:0] w_data,
  input  logic              tx_fifo_rd,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] tx_din,
  output logic              tx_start,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] r_ptr;
  logic              rd_d;
  logic              pop_req;
  logic              push;
  logic              pop;

  assign pop_req = tx_fifo_rd & ~rd_d;

  fifo_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_ctrl (
    .clk     (clk),
    .reset_n (reset_n),
    .wr      (wr),
    .pop_req (pop_req),
    .push    (push),
    .pop     (pop),
    .w_ptr   (w_ptr),
    .r_ptr   (r_ptr),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // Storage has no reset; stale contents are masked by empty.
  always_ff @(posedge clk) begin
    if (push) mem[w_ptr] <= w_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_d     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      rd_d <= tx_fifo_rd;
      // A new drop outranks a simultaneous clear.
      if (wr & full & ~pop) overflow <= 1'b1;
      else if (clr_ovf)     overflow <= 1'b0;
    end
  end

  // Only a pop moves r_ptr, so the head is stable while the strobe is pending.
  assign tx_din   = empty ? '0 : mem[r_ptr];
  assign tx_start = ~empty;

endmodule
